id_ex_stage: RTL and testbench

Execute-stage front end of the pipelined RV32I core: the ID/EX pipeline register plus operand-forwarding muxes that drive `ALUop1`/`ALUop2`/`ALUctrl` into the ALU. It also consumes the ALU's `ZeroE` branch flag to produce the branch-taken select and branch target. It sits between the decode stage and the ALU. Stall and flush requests come from the hazard unit.

---
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with M/W operand forwarding, branch-target adder and
// branch-taken select feeding the execute-stage ALU.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int CONTROL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallE,
  input  logic                     FlushE,
  input  logic [DATA_WIDTH-1:0]    RD1D,
  input  logic [DATA_WIDTH-1:0]    RD2D,
  input  logic [DATA_WIDTH-1:0]    ImmExtD,
  input  logic [DATA_WIDTH-1:0]    PCD,
  input  logic [ADDR_WIDTH-1:0]    Rs1D,
  input  logic [ADDR_WIDTH-1:0]    Rs2D,
  input  logic [ADDR_WIDTH-1:0]    RdD,
  input  logic [CONTROL_WIDTH-1:0] ALUctrlD,
  input  logic                     ALUsrcD,
  input  logic                     RegWriteD,
  input  logic                     MemWriteD,
  input  logic                     BranchD,
  input  logic                     JumpD,
  input  logic [1:0]               ResultSrcD,
  input  logic [DATA_WIDTH-1:0]    ALUResultM,
  input  logic [DATA_WIDTH-1:0]    ResultW,
  input  logic [ADDR_WIDTH-1:0]    RdM,
  input  logic [ADDR_WIDTH-1:0]    RdW,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     ZeroE,
  output logic [DATA_WIDTH-1:0]    ALUop1,
  output logic [DATA_WIDTH-1:0]    ALUop2,
  output logic [CONTROL_WIDTH-1:0] ALUctrlE,
  output logic [DATA_WIDTH-1:0]    WriteDataE,
  output logic [DATA_WIDTH-1:0]    PCTargetE,
  output logic                     PCSrcE,
  output logic [ADDR_WIDTH-1:0]    Rs1E,
  output logic [ADDR_WIDTH-1:0]    Rs2E,
  output logic [ADDR_WIDTH-1:0]    RdE,
  output logic                     RegWriteE,
  output logic                     MemWriteE,
  output logic [1:0]               ResultSrcE,
  output logic [DATA_WIDTH-1:0]    PCE
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [DATA_WIDTH-1:0]    immExt;
    logic [DATA_WIDTH-1:0]    pc;
    logic [ADDR_WIDTH-1:0]    rs1;
    logic [ADDR_WIDTH-1:0]    rs2;
    logic [ADDR_WIDTH-1:0]    rd;
    logic [CONTROL_WIDTH-1:0] aluCtrl;
    logic                     aluSrc;
    logic                     regWrite;
    logic                     memWrite;
    logic                     branch;
    logic                     jump;
    logic [1:0]               resultSrc;
  } exRegs_t;

  exRegs_t ex_d, ex_q;
  logic [DATA_WIDTH-1:0] srcAFwd, srcBFwd;

  // An all-zero bundle is a NOP bubble; flush beats stall.
  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (!StallE) begin
      ex_d.rd1       = RD1D;
      ex_d.rd2       = RD2D;
      ex_d.immExt    = ImmExtD;
      ex_d.pc        = PCD;
      ex_d.rs1       = Rs1D;
      ex_d.rs2       = Rs2D;
      ex_d.rd        = RdD;
      ex_d.aluCtrl   = ALUctrlD;
      ex_d.aluSrc    = ALUsrcD;
      ex_d.regWrite  = RegWriteD;
      ex_d.memWrite  = MemWriteD;
      ex_d.branch    = BranchD;
      ex_d.jump      = JumpD;
      ex_d.resultSrc = ResultSrcD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // Younger producer (M) wins over W; x0 is hardwired and never forwarded.
  always_comb begin
    srcAFwd = ex_q.rd1;
    if (RegWriteM && (RdM != '0) && (RdM == ex_q.rs1))      srcAFwd = ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == ex_q.rs1)) srcAFwd = ResultW;
  end

  always_comb begin
    srcBFwd = ex_q.rd2;
    if (RegWriteM && (RdM != '0) && (RdM == ex_q.rs2))      srcBFwd = ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == ex_q.rs2)) srcBFwd = ResultW;
  end

  assign ALUop1     = srcAFwd;
  assign ALUop2     = ex_q.aluSrc ? ex_q.immExt : srcBFwd;
  assign WriteDataE = srcBFwd;
  assign ALUctrlE   = ex_q.aluCtrl;
  assign PCTargetE  = ex_q.pc + ex_q.immExt;
  assign PCSrcE     = ex_q.jump | (ex_q.branch & ZeroE);
  assign Rs1E       = ex_q.rs1;
  assign Rs2E       = ex_q.rs2;
  assign RdE        = ex_q.rd;
  assign RegWriteE  = ex_q.regWrite;
  assign MemWriteE  = ex_q.memWrite;
  assign ResultSrcE = ex_q.resultSrc;
  assign PCE        = ex_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps followed by random
// traffic, all compared against a behavioural model of the E-stage state.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  ALUctrlD;
  logic        ALUsrcD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]  ResultSrcD;
  logic [31:0] ALUResultM, ResultW;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW, ZeroE;
  logic [31:0] ALUop1, ALUop2, WriteDataE, PCTargetE, PCE;
  logic [2:0]  ALUctrlE;
  logic        PCSrcE, RegWriteE, MemWriteE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [1:0]  ResultSrcE;

  int total = 0;
  int bad   = 0;

  // Model of the instruction currently held in E
  logic [31:0] mRd1, mRd2, mImm, mPc;
  logic [4:0]  mRs1, mRs2, mRd;
  logic [2:0]  mCtrl;
  logic        mSrc, mRegW, mMemW, mBr, mJmp;
  logic [1:0]  mResSrc;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUctrlD(ALUctrlD),
    .ALUsrcD(ALUsrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ZeroE(ZeroE),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrlE(ALUctrlE),
    .WriteDataE(WriteDataE), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .PCE(PCE)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regVal);
    if (rs == 0) return regVal;
    if (RegWriteM && RdM == rs) return ALUResultM;
    if (RegWriteW && RdW == rs) return ResultW;
    return regVal;
  endfunction

  task automatic randomizeD();
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
    Rs1D = 5'($urandom_range(0, 4)); Rs2D = 5'($urandom_range(0, 4));
    RdD = 5'($urandom); ALUctrlD = 3'($urandom);
    ALUsrcD = 1'($urandom); RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
    BranchD = 1'($urandom); JumpD = 1'($urandom); ResultSrcD = 2'($urandom);
  endtask

  task automatic randomizeMW();
    ALUResultM = $urandom; ResultW = $urandom;
    RdM = 5'($urandom_range(0, 4)); RdW = 5'($urandom_range(0, 4));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom); ZeroE = 1'($urandom);
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic applyStimulus();
    logic doClear, doLoad;
    doClear = rst || FlushE;
    doLoad  = !doClear && !StallE;
    @(posedge clk);
    if (doClear) begin
      {mRd1, mRd2, mImm, mPc} = '0;
      {mRs1, mRs2, mRd, mCtrl} = '0;
      {mSrc, mRegW, mMemW, mBr, mJmp, mResSrc} = '0;
    end else if (doLoad) begin
      mRd1 = RD1D; mRd2 = RD2D; mImm = ImmExtD; mPc = PCD;
      mRs1 = Rs1D; mRs2 = Rs2D; mRd = RdD; mCtrl = ALUctrlD;
      mSrc = ALUsrcD; mRegW = RegWriteD; mMemW = MemWriteD;
      mBr = BranchD; mJmp = JumpD; mResSrc = ResultSrcD;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] fa, fb;
    #1;
    fa = fwd(mRs1, mRd1);
    fb = fwd(mRs2, mRd2);
    cmp({tag, ".op1"}, ALUop1, fa);
    cmp({tag, ".op2"}, ALUop2, mSrc ? mImm : fb);
    cmp({tag, ".wdata"}, WriteDataE, fb);
    cmp({tag, ".ctrl"}, 32'(ALUctrlE), 32'(mCtrl));
    cmp({tag, ".target"}, PCTargetE, mPc + mImm);
    cmp({tag, ".pcsrc"}, 32'(PCSrcE), 32'(mJmp | (mBr & ZeroE)));
    cmp({tag, ".idx"}, {17'b0, Rs1E, Rs2E, RdE}, {17'b0, mRs1, mRs2, mRd});
    cmp({tag, ".ctl"}, {28'b0, RegWriteE, MemWriteE, ResultSrcE},
        {28'b0, mRegW, mMemW, mResSrc});
    cmp({tag, ".pc"}, PCE, mPc);
  endtask

  initial begin
    rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    randomizeD();
    randomizeMW();
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    {mRd1, mRd2, mImm, mPc, mRs1, mRs2, mRd, mCtrl} = '0;
    {mSrc, mRegW, mMemW, mBr, mJmp, mResSrc} = '0;

    // Reset with nonzero D inputs
    @(negedge clk);
    rst = 1'b1; RegWriteD = 1'b1; JumpD = 1'b1; PCD = 32'h1234; ZeroE = 1'b1;
    applyStimulus();
    checkOutput("reset");
    cmp("reset.pcsrc0", 32'(PCSrcE), 32'd0);
    cmp("reset.target0", PCTargetE, 32'd0);
    rst = 1'b0;

    // Load and target, register operand then immediate operand
    RD1D = 5; RD2D = 7; ALUsrcD = 0; PCD = 32'h100; ImmExtD = 32'h20;
    Rs1D = 1; Rs2D = 2; BranchD = 0; JumpD = 0;
    applyStimulus();
    checkOutput("load_reg");
    cmp("load_reg.op1c", ALUop1, 32'd5);
    cmp("load_reg.op2c", ALUop2, 32'd7);
    cmp("load_reg.tgtc", PCTargetE, 32'h120);
    ALUsrcD = 1;
    applyStimulus();
    checkOutput("load_imm");
    cmp("load_imm.op2c", ALUop2, 32'h20);
    cmp("load_imm.wdc", WriteDataE, 32'd7);

    // Forwarding priority
    Rs1D = 3; RD1D = 32'h11;
    applyStimulus();
    RdM = 3; RegWriteM = 1; ALUResultM = 32'hAA;
    RdW = 3; RegWriteW = 1; ResultW = 32'hBB;
    checkOutput("fwd_m");
    cmp("fwd_m.c", ALUop1, 32'hAA);
    RegWriteM = 0;
    checkOutput("fwd_w");
    cmp("fwd_w.c", ALUop1, 32'hBB);
    Rs1D = 0; RdM = 0; RegWriteM = 1; RD1D = 32'h55;
    applyStimulus();
    checkOutput("fwd_x0");
    cmp("fwd_x0.c", ALUop1, 32'h55);

    // Flush beats stall, then a 3-cycle stall with changing D
    FlushE = 1; StallE = 1; RegWriteD = 1; RdD = 9;
    applyStimulus();
    checkOutput("flush");
    cmp("flush.rd", 32'(RdE), 32'd0);
    cmp("flush.regw", 32'(RegWriteE), 32'd0);
    FlushE = 0; StallE = 0;
    randomizeD();
    applyStimulus();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      randomizeD();
      randomizeMW();
      applyStimulus();
      checkOutput("stall");
    end
    StallE = 0;

    // Branch select
    BranchD = 1; JumpD = 0;
    applyStimulus();
    ZeroE = 1; checkOutput("br_taken");   cmp("br_taken.c", 32'(PCSrcE), 32'd1);
    ZeroE = 0; checkOutput("br_nottkn");  cmp("br_nottkn.c", 32'(PCSrcE), 32'd0);
    BranchD = 0; JumpD = 1;
    applyStimulus();
    checkOutput("jump");
    cmp("jump.c", 32'(PCSrcE), 32'd1);

    // Target wrap-around
    PCD = 32'hFFFF_FFFC; ImmExtD = 32'd8;
    applyStimulus();
    checkOutput("wrap");
    cmp("wrap.c", PCTargetE, 32'h4);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      randomizeD();
      rst    = ($urandom_range(0, 19) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      StallE = ($urandom_range(0, 3) == 0);
      applyStimulus();
      randomizeMW();
      checkOutput("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
